vec_smult_ctrl: RTL and testbench
=================================

Name: vec_smult_ctrl

Overview:
Issue controller for the single-cycle FP16 scalar-by-vector multiply unit. It is the initiator side of the unit's start/done interface:
- accepts one scalar×vector request from the decode stage over a valid/ready handshake;
- holds the operands stable and drives start until the unit answers with done;
- captures the 256-bit product and the overflow flag;
- presents the result to writeback over a second valid/ready handshake.

A timeout guards against a unit that never raises done. A saturating overflow counter feeds the status registers.

Parameters:
TIMEOUT, 16, max cycles start is held without done before the op is aborted (min 2)
DST_W, 3, width of destination register tag carried through

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_scalar  in  16  FP16 scalar operand
req_vec  in  256  16 x FP16 vector operand, lane i = bits [16i+15:16i]
req_dst  in  DST_W  destination register tag
u_start  out  1  start to multiply unit
u_scalar  out  16  scalar to unit
u_vecin  out  256  vector to unit
u_product  in  256  unit product
u_V  in  1  unit overflow (OR of all lanes)
u_done  in  1  unit completion
res_valid  out  1  result present
res_ready  in  1  writeback accepts result
res_data  out  256  captured product (0 on timeout)
res_ovf  out  1  captured overflow (0 on timeout)
res_timeout  out  1  op aborted by timeout
res_dst  out  DST_W  tag of result
ovf_count  out  16  saturating count of results with res_ovf=1

Behaviour:
Reset:
- All outputs are 0, state is IDLE, and the timeout counter is 0.
- Reset asserted mid-operation abandons the op: no result is produced and ovf_count clears.

States are IDLE, BUSY and RESP.

IDLE:
- req_ready=1 (registered, state-decoded); u_start=0.
- On req_valid&req_ready: latch scalar, vec and dst into operand registers; clear the counter; go to BUSY.

BUSY:
- u_start=1; u_scalar and u_vecin are driven from the operand registers and held constant for the whole state.
- req_ready=0.
- If u_done=1 on a clock edge: capture u_product into res_data and u_V into res_ovf; set res_timeout=0; go to RESP. u_done is sampled only in BUSY and ignored elsewhere.
- Otherwise, if counter==TIMEOUT-1: set res_data=0, res_ovf=0, res_timeout=1; go to RESP.
- Otherwise, increment the counter.
- u_done and the timeout in the same cycle: done wins.

RESP:
- res_valid=1; res_data, res_ovf, res_timeout and res_dst stay stable while res_ready=0.
- u_start=0 and req_ready=0.
- On res_ready: go to IDLE. If res_ovf=1, ovf_count increments, saturating at 16'hFFFF.

Latency and throughput with the combinational unit (done=start):
- Request accepted at edge 0; u_start high during cycle 1; done captured at edge 1; res_valid high from cycle 2.
- With res_ready=1 the handshake completes at edge 2 and req_ready is back in cycle 3.
- Peak throughput is 1 op per 3 cycles.

Other rules:
- No arithmetic is performed here; product bits pass through unmodified.
- The counter width is ceil(log2(TIMEOUT)).
- No request is accepted while BUSY or RESP: there is no skid buffer and no back-to-back acceptance.

Test Plan:
- Real multiply unit attached; scalar 3c00, vec all lanes 3c00, res_ready=1 → u_start high exactly 1 cycle, res_valid in cycle 2 after accept, res_data=3c00 repeated ×16, res_ovf=0, res_timeout=0, res_dst echoed.
- Scalar bc00, vec all 3c00, res_ready held 0 for 5 cycles → res_valid stays 1, res_data=bc00 repeated and stable, req_ready=0 throughout; releases one cycle after res_ready=1.
- Stub unit returning u_V=1 with product 7c00 repeated, three ops → each res_ovf=1, ovf_count=3; ovf_count preset near saturation (forced 16'hFFFE, three more overflow ops) → holds at FFFF.
- Stub unit with u_done tied 0, TIMEOUT=16 → u_start high exactly 16 cycles, then res_valid with res_timeout=1, res_data=0, res_ovf=0; ovf_count unchanged.
- Stub raising u_done on the 16th BUSY cycle (timeout coincident) → res_timeout=0, product captured.
- rst_n pulsed low during BUSY → all outputs 0 immediately (async); no res_valid after release; next request completes normally.

Source files
------------

// File: rtl/vec_smult_ctrl.sv
// vec_smult_ctrl: issue controller for the FP16 scalar-by-vector multiply unit.
// Rev 1.0 - accept request, drive start until done or timeout, hold result for writeback.
`default_nettype none

module vec_smult_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int DST_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_scalar,
  input  logic [255:0]     req_vec,
  input  logic [DST_W-1:0] req_dst,
  output logic             u_start,
  output logic [15:0]      u_scalar,
  output logic [255:0]     u_vecin,
  input  logic [255:0]     u_product,
  input  logic             u_V,
  input  logic             u_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [255:0]     res_data,
  output logic             res_ovf,
  output logic             res_timeout,
  output logic [DST_W-1:0] res_dst,
  output logic [15:0]      ovf_count
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             req_fire, res_fire, done_take, to_take;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_fire  = 1'b0;
    res_fire  = 1'b0;
    done_take = 1'b0;
    to_take   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_fire = 1'b1;
          cnt_n    = '0;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        // done takes priority over a coincident timeout
        if (u_done) begin
          done_take = 1'b1;
          state_n   = RESP;
        end else if (cnt == C_CNT_LAST) begin
          to_take = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_fire = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign u_start   = (state == BUSY);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= (state_n == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_scalar <= '0;
      u_vecin  <= '0;
      res_dst  <= '0;
    end else if (req_fire) begin
      u_scalar <= req_scalar;
      u_vecin  <= req_vec;
      res_dst  <= req_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_timeout <= 1'b0;
    end else if (done_take) begin
      res_data    <= u_product;
      res_ovf     <= u_V;
      res_timeout <= 1'b0;
    end else if (to_take) begin
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (res_fire && res_ovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_smult_ctrl.sv
// tb_vec_smult_ctrl: table-driven and randomized checks of vec_smult_ctrl against a transaction-level model.
`default_nettype none

module tb_vec_smult_ctrl;

  localparam int TIMEOUT = 16;
  localparam int DST_W   = 3;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_scalar;
  logic [255:0]     req_vec;
  logic [DST_W-1:0] req_dst;
  logic             u_start;
  logic [15:0]      u_scalar;
  logic [255:0]     u_vecin;
  logic [255:0]     u_product;
  logic             u_V;
  logic             u_done;
  logic             res_valid;
  logic             res_ready;
  logic [255:0]     res_data;
  logic             res_ovf;
  logic             res_timeout;
  logic [DST_W-1:0] res_dst;
  logic [15:0]      ovf_count;

  int errors = 0;
  int checks = 0;

  // stub unit controls: done after 'dly' start cycles (0 = never)
  int   dly;
  logic vflag;
  logic prod_ovr;
  int   scnt;
  int   model_ovf;

  vec_smult_ctrl #(.TIMEOUT(TIMEOUT), .DST_W(DST_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_scalar(req_scalar), .req_vec(req_vec), .req_dst(req_dst),
    .u_start(u_start), .u_scalar(u_scalar), .u_vecin(u_vecin),
    .u_product(u_product), .u_V(u_V), .u_done(u_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .res_timeout(res_timeout),
    .res_dst(res_dst), .ovf_count(ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unit stand-in: exact for scalar +/-1.0, otherwise an arbitrary lane mix.
  function automatic logic [255:0] unit_mul(input logic [15:0] sc, input logic [255:0] vc);
    logic [255:0] r;
    logic [15:0]  l;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      l = vc[16*i +: 16];
      if (sc[14:0] == 15'h3c00) r[16*i +: 16] = {sc[15] ^ l[15], l[14:0]};
      else                      r[16*i +: 16] = l ^ sc;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (u_start) scnt <= scnt + 1;
    else         scnt <= 0;
  end

  always_comb begin
    u_product = prod_ovr ? {16{16'h7c00}} : unit_mul(u_scalar, u_vecin);
    u_V       = vflag;
    u_done    = u_start && (dly != 0) && (scnt == dly - 1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction, entered and left at a negedge.
  task automatic do_op(input logic [15:0] sc, input logic [255:0] vc, input logic [DST_W-1:0] dst,
                       input int dly_i, input logic v_i, input int stall,
                       input logic [255:0] e_data, input logic e_ovf, input logic e_to, input int e_busy);
    int n;
    bit ok;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", {255'd0, req_ready}, 256'd1);
    dly        = dly_i;
    vflag      = v_i;
    req_valid  = 1'b1;
    req_scalar = sc;
    req_vec    = vc;
    req_dst    = dst;
    @(negedge clk);
    req_valid  = 1'b0;
    req_scalar = 16'($urandom);
    req_vec    = ~vc;
    req_dst    = ~dst;
    chk("u_start_cycle1", {255'd0, u_start}, 256'd1);
    n  = 0;
    ok = 1'b1;
    while (u_start && n < 100) begin
      if (u_scalar !== sc || u_vecin !== vc || req_ready !== 1'b0) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 256'(n), 256'(e_busy));
    chk("operands_held", {255'd0, ok}, 256'd1);
    chk("res_valid", {255'd0, res_valid}, 256'd1);
    if (stall > 0) begin
      ok = 1'b1;
      for (int k = 0; k < stall; k++) begin
        if (!res_valid || res_data !== e_data || req_ready || u_start || res_dst !== dst) ok = 1'b0;
        @(negedge clk);
      end
      chk("res_stable_stall", {255'd0, ok}, 256'd1);
    end
    chk("res_data", res_data, e_data);
    chk("res_ovf", {255'd0, res_ovf}, {255'd0, e_ovf});
    chk("res_timeout", {255'd0, res_timeout}, {255'd0, e_to});
    chk("res_dst", 256'(res_dst), 256'(dst));
    if (e_ovf && model_ovf < 16'hFFFF) model_ovf++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_released", {255'd0, res_valid}, 256'd0);
    chk("req_ready_back", {255'd0, req_ready}, 256'd1);
    chk("ovf_count", 256'(ovf_count), 256'(model_ovf));
  endtask

  // Transaction-level expectation for the randomized ops.
  task automatic rand_op();
    logic [15:0]  sc;
    logic [255:0] vc;
    logic [DST_W-1:0] dst;
    int d, st, busy;
    logic v, to;
    sc = ($urandom_range(0, 3) == 0) ? {1'($urandom), 15'h3c00} : 16'($urandom);
    for (int w = 0; w < 8; w++) vc[32*w +: 32] = $urandom;
    dst = DST_W'($urandom);
    case ($urandom_range(0, 5))
      0: d = 0;
      1: d = 1;
      2: d = 2;
      3: d = TIMEOUT;
      4: d = TIMEOUT + 1;
      default: d = $urandom_range(3, TIMEOUT - 1);
    endcase
    v    = 1'($urandom);
    st   = $urandom_range(0, 3);
    to   = (d == 0) || (d > TIMEOUT);
    busy = to ? TIMEOUT : d;
    do_op(sc, vc, dst, d, v, st, to ? 256'd0 : unit_mul(sc, vc), to ? 1'b0 : v, to, busy);
  endtask

  typedef struct {
    logic [15:0]      sc;
    logic [255:0]     vc;
    logic [DST_W-1:0] dst;
    int               dly;
    logic             v;
    int               stall;
    logic [255:0]     e_data;
    logic             e_ovf;
    logic             e_to;
    int               e_busy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tbl[0] = '{16'h3c00, {16{16'h3c00}}, 3'd5, 1, 1'b0, 0, {16{16'h3c00}}, 1'b0, 1'b0, 1};
    tbl[1] = '{16'hbc00, {16{16'h3c00}}, 3'd2, 1, 1'b0, 5, {16{16'hbc00}}, 1'b0, 1'b0, 1};
    tbl[2] = '{16'h3c00, {16{16'h4000}}, 3'd7, 3, 1'b0, 1, {16{16'h4000}}, 1'b0, 1'b0, 3};
    tbl[3] = '{16'h3c00, {16{16'h1234}}, 3'd1, 0, 1'b1, 0, 256'd0, 1'b0, 1'b1, TIMEOUT};
    tbl[4] = '{16'hbc00, {16{16'h4400}}, 3'd3, TIMEOUT, 1'b0, 2, {16{16'hc400}}, 1'b0, 1'b0, TIMEOUT};
    tbl[5] = '{16'h3c00, {16{16'h5555}}, 3'd6, TIMEOUT + 1, 1'b1, 0, 256'd0, 1'b0, 1'b1, TIMEOUT};

    rst_n = 1'b0; req_valid = 1'b0; req_scalar = '0; req_vec = '0; req_dst = '0;
    res_ready = 1'b0; dly = 1; vflag = 1'b0; prod_ovr = 1'b0; scnt = 0; model_ovf = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {255'd0, req_ready}, 256'd0);
    chk("rst_u_start", {255'd0, u_start}, 256'd0);
    chk("rst_res_valid", {255'd0, res_valid}, 256'd0);
    chk("rst_res_data", res_data, 256'd0);
    chk("rst_ovf_count", 256'(ovf_count), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {255'd0, req_ready}, 256'd1);

    for (int i = 0; i < 6; i++)
      do_op(tbl[i].sc, tbl[i].vc, tbl[i].dst, tbl[i].dly, tbl[i].v, tbl[i].stall,
            tbl[i].e_data, tbl[i].e_ovf, tbl[i].e_to, tbl[i].e_busy);

    prod_ovr = 1'b1;
    for (int i = 0; i < 3; i++)
      do_op(16'h7bff, {16{16'h7bff}}, DST_W'(i), 1, 1'b1, 0, {16{16'h7c00}}, 1'b1, 1'b0, 1);
    chk("ovf_count_three", 256'(ovf_count), 256'd3);
    prod_ovr = 1'b0;

    for (int i = 0; i < 16; i++) rand_op();

    force dut.ovf_count = 16'hFFFE;
    @(negedge clk);
    release dut.ovf_count;
    model_ovf = 16'hFFFE;
    prod_ovr  = 1'b1;
    for (int i = 0; i < 3; i++)
      do_op(16'h7bff, {16{16'h7bff}}, 3'd4, 1, 1'b1, 0, {16{16'h7c00}}, 1'b1, 1'b0, 1);
    chk("ovf_count_sat", 256'(ovf_count), 256'hFFFF);
    prod_ovr = 1'b0;

    // abandon an op with an asynchronous reset mid-BUSY
    dly = 0;
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_scalar = 16'h3c00; req_vec = {16{16'h3c00}}; req_dst = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {255'd0, u_start}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_u_start", {255'd0, u_start}, 256'd0);
    chk("async_req_ready", {255'd0, req_ready}, 256'd0);
    chk("async_res_valid", {255'd0, res_valid}, 256'd0);
    chk("async_ovf_count", 256'(ovf_count), 256'd0);
    chk("async_u_vecin", u_vecin, 256'd0);
    model_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || u_start) ok = 1'b0;
    end
    chk("no_result_after_rst", {255'd0, ok}, 256'd1);
    do_op(tbl[0].sc, tbl[0].vc, tbl[0].dst, tbl[0].dly, tbl[0].v, tbl[0].stall,
          tbl[0].e_data, tbl[0].e_ovf, tbl[0].e_to, tbl[0].e_busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
